// File: rtl/sd_cmd_reg_resp_if.sv
// Register-bus and command-engine signals between the command-issue sequencer
// and the SD command register responder.
interface sd_cmd_reg_resp_if;
  logic         wr_reg_strb;
  logic [11:0]  wr_reg_index;
  logic [31:0]  wr_reg_output;
  logic [2:0]   reg_attr;
  logic [11:0]  rd_reg_index;
  logic [127:0] rd_reg_input;
  logic         new_cmd_set_strb;
  logic [31:0]  cmd_arg;
  logic [15:0]  cmd_reg;
  logic         cmd_done_strb;
  logic [127:0] cmd_resp;
  logic         xfer_done_strb;

  modport slave (
    input  wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr, rd_reg_index,
           cmd_done_strb, cmd_resp, xfer_done_strb,
    output rd_reg_input, new_cmd_set_strb, cmd_arg, cmd_reg
  );

  modport master (
    output wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr, rd_reg_index,
           cmd_done_strb, cmd_resp, xfer_done_strb,
    input  rd_reg_input, new_cmd_set_strb, cmd_arg, cmd_reg
  );
endinterface

// File: rtl/sd_cmd_reg_resp.sv
// SD host command register responder: decodes register accesses, tracks CMD/DAT
// inhibits, launches the command-line engine and collects completion/timeout status.
module sd_cmd_reg_resp #(
  parameter int                 TOUT_W   = 16,
  parameter logic [TOUT_W-1:0]  TOUT_MAX = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  sd_cmd_reg_resp_if.slave    bus
);

  localparam logic [11:0] A_ARG  = 12'h008;
  localparam logic [11:0] A_CMD  = 12'h00E;
  localparam logic [11:0] A_RESP = 12'h010;
  localparam logic [11:0] A_PST  = 12'h024;
  localparam logic [11:0] A_NIS  = 12'h030;
  localparam logic [11:0] A_EIS  = 12'h032;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    BUSY  = 4'b0100,
    DONE  = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic [TOUT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]        arg_q, arg_d;
  logic [15:0]        cmd_reg_q, cmd_reg_d;
  logic [127:0]       resp_q, resp_d;
  logic               cmd_inhibit_q, cmd_inhibit_d;
  logic               dat_inhibit_q, dat_inhibit_d;
  logic               cmd_compl_q, cmd_compl_d;
  logic               tf_compl_q, tf_compl_d;
  logic               cmd_tout_q, cmd_tout_d;
  logic [127:0]       rd_q, rd_d;

  logic wr_norm, wr_rw1c, cmd_ok;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    arg_d         = arg_q;
    cmd_reg_d     = cmd_reg_q;
    resp_d        = resp_q;
    cmd_inhibit_d = cmd_inhibit_q;
    dat_inhibit_d = dat_inhibit_q;
    cmd_compl_d   = cmd_compl_q;
    tf_compl_d    = tf_compl_q;
    cmd_tout_d    = cmd_tout_q;

    wr_norm = bus.wr_reg_strb && (bus.reg_attr == 3'h0);
    wr_rw1c = bus.wr_reg_strb && (bus.reg_attr == 3'h1);
    cmd_ok  = wr_norm && (bus.wr_reg_index == A_CMD) && (state_q == IDLE) &&
              !cmd_inhibit_q && !(bus.wr_reg_output[5] && dat_inhibit_q);

    if (wr_norm && (bus.wr_reg_index == A_ARG)) arg_d = bus.wr_reg_output;

    // Clears are applied before any set below so a same-cycle set wins.
    if (wr_rw1c && (bus.wr_reg_index == A_NIS)) begin
      cmd_compl_d = cmd_compl_q & ~bus.wr_reg_output[0];
      tf_compl_d  = tf_compl_q  & ~bus.wr_reg_output[1];
    end
    if (wr_rw1c && (bus.wr_reg_index == A_EIS))
      cmd_tout_d = cmd_tout_q & ~bus.wr_reg_output[0];

    if (bus.xfer_done_strb) begin
      if (dat_inhibit_q) tf_compl_d = 1'b1;
      dat_inhibit_d = 1'b0;
    end

    unique case (state_q)
      IDLE: if (cmd_ok) begin
        cmd_reg_d     = bus.wr_reg_output[15:0];
        cmd_inhibit_d = 1'b1;
        if (bus.wr_reg_output[5]) dat_inhibit_d = 1'b1;
        state_d       = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.cmd_done_strb) begin
          if (cmd_reg_q[1:0] != 2'b00) resp_d = bus.cmd_resp;
          cmd_compl_d   = 1'b1;
          cmd_inhibit_d = 1'b0;
          state_d       = DONE;
        end else if (cnt_q == TOUT_MAX) begin
          cmd_tout_d    = 1'b1;
          cmd_inhibit_d = 1'b0;
          dat_inhibit_d = 1'b0;
          state_d       = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d       = IDLE;
        cmd_inhibit_d = 1'b0;
        dat_inhibit_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_d = '0;
    case (bus.rd_reg_index)
      A_ARG:  rd_d = {96'b0, arg_q};
      A_CMD:  rd_d = {112'b0, cmd_reg_q};
      A_RESP: rd_d = resp_q;
      A_PST:  rd_d = {126'b0, dat_inhibit_q, cmd_inhibit_q};
      A_NIS:  rd_d = {126'b0, tf_compl_q, cmd_compl_q};
      A_EIS:  rd_d = {127'b0, cmd_tout_q};
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      arg_q         <= '0;
      cmd_reg_q     <= '0;
      resp_q        <= '0;
      cmd_inhibit_q <= 1'b0;
      dat_inhibit_q <= 1'b0;
      cmd_compl_q   <= 1'b0;
      tf_compl_q    <= 1'b0;
      cmd_tout_q    <= 1'b0;
      rd_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      arg_q         <= arg_d;
      cmd_reg_q     <= cmd_reg_d;
      resp_q        <= resp_d;
      cmd_inhibit_q <= cmd_inhibit_d;
      dat_inhibit_q <= dat_inhibit_d;
      cmd_compl_q   <= cmd_compl_d;
      tf_compl_q    <= tf_compl_d;
      cmd_tout_q    <= cmd_tout_d;
      rd_q          <= rd_d;
    end
  end

  assign bus.rd_reg_input     = rd_q;
  assign bus.new_cmd_set_strb = (state_q == ISSUE);
  assign bus.cmd_arg          = arg_q;
  assign bus.cmd_reg          = cmd_reg_q;

endmodule
